// File: rtl/vx_icache_pkg.sv
// vx_icache_pkg: shared types and constants for the instruction-cache responder.
//   - state_e      : fill FSM state (IDLE / REQ / WAIT), 2-bit encoding
//   - DEF_*        : default geometry of the block
//   - OFF_W/IDX_W/TAG_W : PC field widths for the default geometry
//   - line_addr_t  : line address (PC with word offset and byte bits dropped)
// Modules take LINES/LINE_WORDS/ADDR_W as parameters and derive their own
// field widths, so a non-default instance stays self-consistent.
package vx_icache_pkg;

  localparam int DEF_LINES      = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef logic [DEF_ADDR_W-OFF_W-3:0] line_addr_t;

endpackage

// File: rtl/vx_icache_store.sv
// vx_icache_store: direct-mapped line store (valid bits, tags, data words).
// Ports:
//   clk, reset            clock, async active-high reset (clears valid bits only)
//   rd_idx/rd_off         combinational read address
//   rd_valid/rd_tag/rd_word  read results for that line/word
//   wr_en/wr_idx/wr_off/wr_data  single-word fill write
//   set_en/set_idx/set_tag       write tag and mark line valid
//   clear_all             invalidate every line (takes priority over set_en)
module vx_icache_store #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 26,
  parameter int IDX_BITS   = $clog2(LINES),
  parameter int OFF_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_word,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [31:0]         wr_data,
  input  logic                set_en,
  input  logic [IDX_BITS-1:0] set_idx,
  input  logic [TAG_BITS-1:0] set_tag,
  input  logic                clear_all
);

  logic [LINES-1:0]                         valid_q;
  logic [LINES-1:0][TAG_BITS-1:0]           tag_q;
  logic [LINES-1:0][LINE_WORDS-1:0][31:0]   data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          valid_q <= '0;
    else if (clear_all) valid_q <= '0;
    else if (set_en)    valid_q[set_idx] <= 1'b1;
  end

  // Tag and data contents are don't-care while the valid bit is low.
  always_ff @(posedge clk) begin
    if (set_en) tag_q[set_idx] <= set_tag;
    if (wr_en)  data_q[wr_idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/vx_icache_responder.sv
// vx_icache_responder: fetch-side instruction responder with a direct-mapped
// line store. Hits return the instruction combinationally; a miss freezes
// fetch, fills the line in LINE_WORDS beats, then releases.
// Ports:
//   clk, reset                    clock, async active-high reset
//   in_pc_valid, in_pc, in_flush  fetch PC and fence.i invalidate
//   out_instruction, out_freeze   instruction (0 unless hit), fetch stall
//   mem_req_valid/ready/addr      line-fill request handshake
//   mem_rsp_valid/data            fill beats, ascending word order
//   out_hit_count/out_miss_count  only when VX_ICACHE_PERF_EN is defined
// Optional feature macro: VX_ICACHE_PERF_EN (saturating hit/miss counters).
module vx_icache_responder
  import vx_icache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_pc_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_flush,
  output logic [31:0]       out_instruction,
  output logic              out_freeze,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef VX_ICACHE_PERF_EN
  ,
  output logic [31:0]       out_hit_count,
  output logic [31:0]       out_miss_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;

  logic [OFF_BITS-1:0] pc_off;
  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic                unused_pc_lsb;

  assign pc_off        = in_pc[2 +: OFF_BITS];
  assign pc_idx        = in_pc[2+OFF_BITS +: IDX_BITS];
  assign pc_tag        = in_pc[ADDR_W-1 -: TAG_BITS];
  assign unused_pc_lsb = ^in_pc[1:0];

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] beat_q;
  logic [IDX_BITS-1:0] fill_idx_q;
  logic [TAG_BITS-1:0] fill_tag_q;
  logic                flush_pend_q;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_word;
  logic                hit, start_fill, wr_en, last_beat, set_en;

  assign hit             = in_pc_valid && rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
  assign out_instruction = hit ? rd_word : 32'd0;
  assign wr_en           = (state_q == WAIT) && mem_rsp_valid;
  assign last_beat       = wr_en && (beat_q == OFF_BITS'(LINE_WORDS-1));
  // A flush seen at any point during the fill (or on the final beat) leaves
  // the line invalid: its data may predate the fence.i.
  assign set_en          = last_beat && !flush_pend_q && !in_flush;
  assign mem_req_addr    = {fill_tag_q, fill_idx_q, {(OFF_BITS+2){1'b0}}};

  vx_icache_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_idx),
    .rd_off    (pc_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (wr_en),
    .wr_idx    (fill_idx_q),
    .wr_off    (beat_q),
    .wr_data   (mem_rsp_data),
    .set_en    (set_en),
    .set_idx   (fill_idx_q),
    .set_tag   (fill_tag_q),
    .clear_all (in_flush)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    out_freeze    = 1'b0;
    start_fill    = 1'b0;
    case (state_q)
      IDLE: begin
        // Also covers the cycle after a fill whose line was flushed or whose
        // PC moved: a fresh miss stalls again immediately.
        if (in_pc_valid && !hit) begin
          out_freeze = 1'b1;
          start_fill = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        out_freeze    = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        out_freeze = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q       <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (start_fill) begin
        fill_idx_q <= pc_idx;
        fill_tag_q <= pc_tag;
      end
      if (state_q == REQ && mem_req_ready) beat_q <= '0;
      else if (wr_en)                      beat_q <= beat_q + 1'b1;
      if (state_q == IDLE) flush_pend_q <= 1'b0;
      else if (in_flush)   flush_pend_q <= 1'b1;
    end
  end

`ifdef VX_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && hit_cnt_q != '1)         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start_fill && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign out_hit_count  = hit_cnt_q;
  assign out_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_vx_icache_responder.sv
module tb_vx_icache_responder;

  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_pc_valid;
  logic [31:0] in_pc;
  logic        in_flush;
  logic [31:0] out_instruction;
  logic        out_freeze;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
`ifdef VX_ICACHE_PERF_EN
  logic [31:0] out_hit_count, out_miss_count;
`endif

  vx_icache_responder #(.LINES(16), .LINE_WORDS(LINE_WORDS), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_pc_valid     (in_pc_valid),
    .in_pc           (in_pc),
    .in_flush        (in_flush),
    .out_instruction (out_instruction),
    .out_freeze      (out_freeze),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data)
`ifdef VX_ICACHE_PERF_EN
    ,
    .out_hit_count   (out_hit_count),
    .out_miss_count  (out_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every delivered instruction and every accepted fill request is
  // matched against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (!reset && in_pc_valid && !out_freeze) begin
      if (exp_instr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_hit: got 0x%08h for pc 0x%08h, none expected", out_instruction, in_pc);
      end else begin
        mon_e = exp_instr_q.pop_front();
        chk("hit_instr", out_instruction, mon_e);
      end
    end
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr 0x%08h, none expected", mem_req_addr);
      end else begin
        mon_e = exp_addr_q.pop_front();
        chk("req_addr", mem_req_addr, mon_e);
      end
    end
  end

  task automatic present(input logic [31:0] pc);
    in_pc       = pc;
    in_pc_valid = 1'b1;
  endtask

  // Memory side: accept one request (optionally stalling ready), then return
  // LINE_WORDS beats base+0..base+3. flush_beat asserts in_flush with that
  // beat; abort_beat asserts reset instead of driving that beat.
  task automatic serve_fill(input logic [31:0] line, input logic [31:0] base,
                            input int delay, input int flush_beat, input int abort_beat);
    int n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, mem_req_valid}, 32'd1);
    if (!mem_req_valid) return;
    exp_addr_q.push_back(line);
    for (int i = 0; i < delay; i++) begin
      chk("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("stall_req_addr", mem_req_addr, line);
      chk("stall_freeze", {31'd0, out_freeze}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1 mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (b == abort_beat) begin
        reset         = 1'b1;
        mem_rsp_valid = 1'b0;
        in_pc_valid   = 1'b0;
        return;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + b;
      in_flush      = (b == flush_beat);
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;
    in_flush      = 1'b0;
  endtask

  // Hold the PC until fetch is released (the monitor checks that hit cycle).
  task automatic wait_release();
    int n = 0;
    @(negedge clk);
    while (out_freeze && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (out_freeze) begin
      checks++; errors++;
      $display("FAIL release_timeout: freeze still 1 after %0d cycles, expected 0", n);
    end
    @(posedge clk); #1 in_pc_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_pc_valid = 1'b0; in_pc = '0; in_flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    chk("rst_freeze", {31'd0, out_freeze}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_instr", out_instruction, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1. cold miss at 0x100
    present(32'h100);
    @(negedge clk);
    chk("cold_freeze_same_cycle", {31'd0, out_freeze}, 32'd1);
    chk("cold_no_req_yet", {31'd0, mem_req_valid}, 32'd0);
    exp_instr_q.push_back(32'hA0);
    serve_fill(32'h100, 32'hA0, 0, -1, -1);
    wait_release();

    // 2. warm hits on consecutive cycles
    exp_instr_q.push_back(32'hA1);
    exp_instr_q.push_back(32'hA2);
    exp_instr_q.push_back(32'hA3);
    present(32'h104); @(negedge clk); chk("warm_freeze_104", {31'd0, out_freeze}, 32'd0);
    @(posedge clk); #1 present(32'h108);
    @(negedge clk); chk("warm_freeze_108", {31'd0, out_freeze}, 32'd0);
    @(posedge clk); #1 present(32'h10C);
    @(negedge clk); chk("warm_freeze_10c", {31'd0, out_freeze}, 32'd0);
    @(posedge clk); #1 in_pc_valid = 1'b0;
    @(negedge clk);
    chk("novalid_instr", out_instruction, 32'd0);
    chk("novalid_freeze", {31'd0, out_freeze}, 32'd0);

    // 3. conflict: 0x500 evicts 0x100, which then misses again
    @(posedge clk); #1 present(32'h500);
    exp_instr_q.push_back(32'hB0);
    serve_fill(32'h500, 32'hB0, 0, -1, -1);
    wait_release();
    present(32'h100);
    @(negedge clk);
    chk("conflict_remiss_freeze", {31'd0, out_freeze}, 32'd1);
    exp_instr_q.push_back(32'hA0);
    serve_fill(32'h100, 32'hA0, 0, -1, -1);
    wait_release();

    // 5. request stalled 5 cycles on ready, other line/offset
    present(32'h248);
    exp_instr_q.push_back(32'hC2);
    serve_fill(32'h240, 32'hC0, 5, -1, -1);
    wait_release();

    // 4. flush in IDLE serves the same-cycle hit, then flush during WAIT
    present(32'h104);
    in_flush = 1'b1;
    exp_instr_q.push_back(32'hA1);
    @(negedge clk);
    chk("flush_idle_hit_freeze", {31'd0, out_freeze}, 32'd0);
    @(posedge clk); #1 in_flush = 1'b0;
    @(negedge clk);
    chk("after_flush_miss", {31'd0, out_freeze}, 32'd1);
    exp_instr_q.push_back(32'hA1);
    serve_fill(32'h100, 32'hA0, 0, 2, -1);
    @(negedge clk);
    chk("flushed_fill_still_miss", {31'd0, out_freeze}, 32'd1);
    chk("flushed_fill_instr", out_instruction, 32'd0);
    serve_fill(32'h100, 32'hA0, 0, -1, -1);
    wait_release();

    // 6. reset during beat 2, then stray beats
    present(32'h300);
    serve_fill(32'h300, 32'hD0, 0, -1, 2);
    @(negedge clk);
    chk("midfill_rst_freeze", {31'd0, out_freeze}, 32'd0);
    chk("midfill_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("midfill_rst_req_addr", mem_req_addr, 32'd0);
`ifdef VX_ICACHE_PERF_EN
    chk("rst_hit_count", out_hit_count, 32'd0);
    chk("rst_miss_count", out_miss_count, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hEE;
    @(negedge clk);
    chk("stray_freeze", {31'd0, out_freeze}, 32'd0);
    chk("stray_req_valid", {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    present(32'h100);
    @(negedge clk);
    chk("post_rst_line_invalid", {31'd0, out_freeze}, 32'd1);
    exp_instr_q.push_back(32'hA0);
    serve_fill(32'h100, 32'hA0, 0, -1, -1);
    wait_release();
    @(negedge clk);
`ifdef VX_ICACHE_PERF_EN
    chk("perf_hit_count", out_hit_count, 32'd1);
    chk("perf_miss_count", out_miss_count, 32'd1);
`endif

    chk("instr_queue_drained", exp_instr_q.size(), 32'd0);
    chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule
